// File: rtl/decode_stage.sv
// decode_stage: IF/ID register, combinational RV32 decoder, ID/EX register.
// Two-edge latency from instr_in/stop_in to the decoded outputs.
// Optional build macro: DECODE_UTYPE_EN adds LUI/AUIPC decoding; when it is
// left undefined, both opcodes decode as bubbles.
module decode_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr_in,
    input  logic        stop_in,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  srcReg1,
    output logic [4:0]  srcReg2,
    output logic [4:0]  destReg,
    output logic [31:0] imm,
    output logic [1:0]  lwSw,
    output logic [1:0]  aluOp,
    output logic        regWrite,
    output logic        aluSrc,
    output logic        branch,
    output logic        memRead,
    output logic        memWrite,
    output logic        memToReg,
    output logic        stop
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IALU   = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_ITYPE  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [1:0]  lw_sw;
        logic [1:0]  alu_op;
        logic        reg_write;
        logic        alu_src;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        stop;
    } idex_t;

    logic [31:0] instr_q;
    logic        stop_q;
    idex_t       idex_d;
    idex_t       idex_q;

    logic [6:0]  op;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [4:0]  rd_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic        valid;

    assign op    = instr_q[6:0];
    assign rs1_f = instr_q[19:15];
    assign rs2_f = instr_q[24:20];
    assign rd_f  = instr_q[11:7];
    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                    instr_q[30:25], instr_q[11:8], 1'b0};

    // IF/ID register: capture the fetched instruction and stop flag every cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instr_q <= '0;
            stop_q  <= 1'b0;
        end else begin
            instr_q <= instr_in;
            stop_q  <= stop_in;
        end
    end

    // Decoder: unknown opcodes and stopped entries fall through as all-zero bubbles
    always_comb begin
        idex_d      = '0;
        idex_d.stop = stop_q;
        valid       = 1'b0;
        if (!stop_q) begin
            case (op)
                OP_RTYPE: begin
                    valid            = 1'b1;
                    idex_d.rs1       = rs1_f;
                    idex_d.rs2       = rs2_f;
                    idex_d.rd        = rd_f;
                    idex_d.alu_op    = ALU_RTYPE;
                    idex_d.reg_write = 1'b1;
                end
                OP_IALU: begin
                    valid            = 1'b1;
                    idex_d.rs1       = rs1_f;
                    idex_d.rd        = rd_f;
                    idex_d.imm       = imm_i;
                    idex_d.alu_op    = ALU_ITYPE;
                    idex_d.alu_src   = 1'b1;
                    idex_d.reg_write = 1'b1;
                end
                OP_LOAD: begin
                    valid             = 1'b1;
                    idex_d.rs1        = rs1_f;
                    idex_d.rd         = rd_f;
                    idex_d.imm        = imm_i;
                    idex_d.alu_op     = ALU_ADD;
                    idex_d.alu_src    = 1'b1;
                    idex_d.reg_write  = 1'b1;
                    idex_d.mem_read   = 1'b1;
                    idex_d.mem_to_reg = 1'b1;
                    idex_d.lw_sw      = 2'b01;
                end
                OP_STORE: begin
                    valid            = 1'b1;
                    idex_d.rs1       = rs1_f;
                    idex_d.rs2       = rs2_f;
                    idex_d.imm       = imm_s;
                    idex_d.alu_op    = ALU_ADD;
                    idex_d.alu_src   = 1'b1;
                    idex_d.mem_write = 1'b1;
                    idex_d.lw_sw     = 2'b10;
                end
                OP_BRANCH: begin
                    valid         = 1'b1;
                    idex_d.rs1    = rs1_f;
                    idex_d.rs2    = rs2_f;
                    idex_d.imm    = imm_b;
                    idex_d.alu_op = ALU_BRANCH;
                    idex_d.branch = 1'b1;
                end
`ifdef DECODE_UTYPE_EN
                OP_LUI, OP_AUIPC: begin
                    valid            = 1'b1;
                    idex_d.rd        = rd_f;
                    idex_d.imm       = {instr_q[31:12], 12'b0};
                    idex_d.alu_op    = ALU_ADD;
                    idex_d.alu_src   = 1'b1;
                    idex_d.reg_write = 1'b1;
                end
`endif
                default: valid = 1'b0;
            endcase
        end
        if (valid) begin
            idex_d.opcode = op;
            idex_d.funct3 = instr_q[14:12];
            idex_d.funct7 = instr_q[31:25];
        end
        // Writes to x0 are architecturally discarded, so never request them
        if (rd_f == 5'd0) begin
            idex_d.reg_write = 1'b0;
        end
    end

    // ID/EX register: capture every decoder output every cycle, no stall or flush
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign opcode   = idex_q.opcode;
    assign funct3   = idex_q.funct3;
    assign funct7   = idex_q.funct7;
    assign srcReg1  = idex_q.rs1;
    assign srcReg2  = idex_q.rs2;
    assign destReg  = idex_q.rd;
    assign imm      = idex_q.imm;
    assign lwSw     = idex_q.lw_sw;
    assign aluOp    = idex_q.alu_op;
    assign regWrite = idex_q.reg_write;
    assign aluSrc   = idex_q.alu_src;
    assign branch   = idex_q.branch;
    assign memRead  = idex_q.mem_read;
    assign memWrite = idex_q.mem_write;
    assign memToReg = idex_q.mem_to_reg;
    assign stop     = idex_q.stop;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven streaming check of decode_stage plus
// hand-written reset sequences. Expected fields follow the RV32 encodings.
module tb_decode_stage;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [1:0]  lwSw;
        logic [1:0]  aluOp;
        logic        regWrite;
        logic        aluSrc;
        logic        branch;
        logic        memRead;
        logic        memWrite;
        logic        memToReg;
        logic        stop;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        stop_in;
        out_t        exp;
    } vec_t;

    logic        clk;
    logic        rstn;
    logic [31:0] instr_in;
    logic        stop_in;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  srcReg1;
    logic [4:0]  srcReg2;
    logic [4:0]  destReg;
    logic [31:0] imm;
    logic [1:0]  lwSw;
    logic [1:0]  aluOp;
    logic        regWrite;
    logic        aluSrc;
    logic        branch;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        stop;

    int unsigned n_checks;
    int unsigned n_fail;
    vec_t        vecs[$];
    out_t        zero_out;

    decode_stage dut (
        .clk      (clk),
        .rstn     (rstn),
        .instr_in (instr_in),
        .stop_in  (stop_in),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .srcReg1  (srcReg1),
        .srcReg2  (srcReg2),
        .destReg  (destReg),
        .imm      (imm),
        .lwSw     (lwSw),
        .aluOp    (aluOp),
        .regWrite (regWrite),
        .aluSrc   (aluSrc),
        .branch   (branch),
        .memRead  (memRead),
        .memWrite (memWrite),
        .memToReg (memToReg),
        .stop     (stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic out_t actual();
        out_t a;
        a = '{opcode, funct3, funct7, srcReg1, srcReg2, destReg, imm, lwSw,
              aluOp, regWrite, aluSrc, branch, memRead, memWrite, memToReg, stop};
        return a;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = actual();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // opcode funct3 funct7 rs1 rs2 rd imm lwSw aluOp regWrite aluSrc branch memRead memWrite memToReg stop
    function automatic out_t o(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                               input logic [31:0] im, input logic [1:0] ls, input logic [1:0] ao,
                               input logic rw, input logic as, input logic br, input logic mr,
                               input logic mw, input logic m2r, input logic st);
        out_t r;
        r = '{op, f3, f7, r1, r2, rd, im, ls, ao, rw, as, br, mr, mw, m2r, st};
        return r;
    endfunction

    task automatic add_vec(input string name, input logic [31:0] instr,
                           input logic st, input out_t exp);
        vec_t v;
        v.name    = name;
        v.instr   = instr;
        v.stop_in = st;
        v.exp     = exp;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        zero_out = '0;

        add_vec("add_x3_x1_x2", 32'h002081B3, 1'b0,
                o(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0));
        add_vec("addi_x5_x0_m1", 32'hFFF00293, 1'b0,
                o(7'h13, 3'd0, 7'h7F, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 2'b00, 2'b11, 1, 1, 0, 0, 0, 0, 0));
        add_vec("lw_x6_8_x2", 32'h00812303, 1'b0,
                o(7'h03, 3'd2, 7'h00, 5'd2, 5'd0, 5'd6, 32'd8, 2'b01, 2'b00, 1, 1, 0, 1, 0, 1, 0));
        add_vec("sw_x6_12_x2", 32'h00612623, 1'b0,
                o(7'h23, 3'd2, 7'h00, 5'd2, 5'd6, 5'd0, 32'd12, 2'b10, 2'b00, 0, 1, 0, 0, 1, 0, 0));
        add_vec("beq_x1_x2_m4", 32'hFE208EE3, 1'b0,
                o(7'h63, 3'd0, 7'h7F, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0, 0));
        add_vec("sw_x1_m4_x2", 32'hFE112E23, 1'b0,
                o(7'h23, 3'd2, 7'h7F, 5'd2, 5'd1, 5'd0, 32'hFFFFFFFC, 2'b10, 2'b00, 0, 1, 0, 0, 1, 0, 0));
        add_vec("add_x0_rd0", 32'h00208033, 1'b0,
                o(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'h0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        add_vec("nop_addi_x0", 32'h00000013, 1'b0,
                o(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 2'b11, 0, 1, 0, 0, 0, 0, 0));
        add_vec("zero_bubble", 32'h00000000, 1'b0, zero_out);
        add_vec("unknown_op", 32'hFFFFFFFF, 1'b0, zero_out);
        add_vec("add_with_stop", 32'h002081B3, 1'b1,
                o(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1));
`ifdef DECODE_UTYPE_EN
        add_vec("lui_x1_0", 32'h000000B7, 1'b0,
                o(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h0, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0));
        add_vec("auipc_x2_1", 32'h00001117, 1'b0,
                o(7'h17, 3'd1, 7'h00, 5'd0, 5'd0, 5'd2, 32'h00001000, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0));
`else
        add_vec("lui_x1_0", 32'h000000B7, 1'b0, zero_out);
        add_vec("auipc_x2_1", 32'h00001117, 1'b0, zero_out);
`endif
        add_vec("add_after_stop", 32'h002081B3, 1'b0,
                o(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0));

        // Reset state
        rstn     = 1'b0;
        instr_in = 32'h002081B3;
        stop_in  = 1'b1;
        @(negedge clk);
        check("reset_state", zero_out);
        @(negedge clk);
        check("reset_held_over_edge", zero_out);
        rstn     = 1'b1;
        instr_in = '0;
        stop_in  = 1'b0;

        // Streaming vectors, one per cycle, outputs checked two edges later
        for (int i = 0; i < vecs.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) check(vecs[i-2].name, vecs[i-2].exp);
            if (i < vecs.size()) begin
                instr_in = vecs[i].instr;
                stop_in  = vecs[i].stop_in;
            end else begin
                instr_in = '0;
                stop_in  = 1'b0;
            end
        end

        // Reset mid-stream: add then addi in flight, then asynchronous reset
        @(negedge clk);
        instr_in = 32'h002081B3;
        @(negedge clk);
        instr_in = 32'hFFF00293;
        @(negedge clk);
        check("midstream_add_before_reset", vecs[0].exp);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midstream_async_clear", zero_out);
        @(negedge clk);
        check("midstream_reset_held", zero_out);
        rstn     = 1'b1;
        instr_in = 32'h002081B3;
        @(negedge clk);
        check("post_reset_one_edge", zero_out);
        instr_in = 32'hFFF00293;
        @(negedge clk);
        check("post_reset_two_edges", vecs[0].exp);
        instr_in = '0;
        @(negedge clk);
        check("post_reset_addi", vecs[1].exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
